multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Five-state multicycle datapath: FETCH/DECODE/EXECUTE/MEM/WB sharing one memory port.
// Control signals come from an external decoder that watches the Instruction output.
module multicycle_datapath #(
    parameter int unsigned BITS      = 64,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned BR_SHIFT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [31:0]          Instruction,
    input  logic [1:0]           ALUControl,
    input  logic                 RegWrite,
    input  logic                 MemWrite,
    input  logic                 Branch,
    input  logic                 MemToReg,
    input  logic                 ALUScr,
    input  logic [BITS-1:0]      Imm,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [BITS-1:0]      mem_wdata,
    input  logic [BITS-1:0]      mem_rdata,
    input  logic                 mem_ready,
    output logic [ADDR_BITS-1:0] pc,
    output logic [2:0]           state,
    output logic                 retire
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  pc_q, pc_d, oldpc_q, oldpc_d;
    logic [31:0]           ir_q, ir_d;
    logic [BITS-1:0]       a_q, a_d, b_q, b_d;
    logic [BITS-1:0]       aluout_q, aluout_d, mdr_q, mdr_d;
    logic [3:0]            flags_q, flags_d;
    logic [BITS-1:0]       regs_q [32];

    logic [4:0]            rs1, rs2, rd;
    logic [BITS-1:0]       rd1, rd2;
    logic                  rf_we;
    logic [BITS-1:0]       rf_wdata;
    logic                  req_c, retire_c;

    logic [BITS-1:0]       src_b, alu_res, imm_sh;
    logic [BITS:0]         sum_ext;
    logic                  alu_c, alu_v, alu_n, alu_z;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];
    assign rd1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    assign imm_sh = Imm << BR_SHIFT;

    always_comb begin
        src_b   = ALUScr ? Imm : b_q;
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            2'b00: begin
                sum_ext = {1'b0, a_q} + {1'b0, src_b};
                alu_res = sum_ext[BITS-1:0];
                alu_c   = sum_ext[BITS];
                alu_v   = (a_q[BITS-1] == src_b[BITS-1]) && (alu_res[BITS-1] != a_q[BITS-1]);
            end
            2'b01: begin
                // Subtract as A + ~B + 1 so the carry-out is the not-borrow flag.
                sum_ext = {1'b0, a_q} + {1'b0, ~src_b} + (BITS+1)'(1);
                alu_res = sum_ext[BITS-1:0];
                alu_c   = sum_ext[BITS];
                alu_v   = (a_q[BITS-1] != src_b[BITS-1]) && (alu_res[BITS-1] != a_q[BITS-1]);
            end
            2'b10:   alu_res = a_q & src_b;
            default: alu_res = a_q | src_b;
        endcase
        alu_n = alu_res[BITS-1];
        alu_z = (alu_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        oldpc_d   = oldpc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        aluout_d  = aluout_q;
        mdr_d     = mdr_q;
        flags_d   = flags_q;
        req_c     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        retire_c  = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = aluout_q;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    oldpc_d = pc_q;
                    pc_d    = pc_q + ADDR_BITS'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rd1;
                b_d     = rd2;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                aluout_d = alu_res;
                flags_d  = {alu_v, alu_c, alu_n, alu_z};
                if (Branch) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                    if (alu_z) pc_d = oldpc_q + imm_sh[ADDR_BITS-1:0];
                end else if (MemWrite || MemToReg) begin
                    state_d = S_MEM;
                end else if (RegWrite) begin
                    state_d = S_WB;
                end else begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                req_c     = 1'b1;
                mem_addr  = aluout_q[ADDR_BITS-1:0];
                mem_we    = MemWrite;
                mem_wdata = b_q;
                if (mem_ready) begin
                    if (MemWrite) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = RegWrite;
                rf_wdata = MemToReg ? mdr_q : aluout_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            oldpc_q  <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (rf_we && (rd != 5'd0)) begin
            regs_q[rd] <= rf_wdata;
        end
    end

    // Reset masks the strobes so nothing is requested or retired while rst is high.
    assign mem_req     = req_c & ~rst;
    assign retire      = retire_c & ~rst;
    assign Instruction = ir_q;
    assign pc          = pc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: acts as decoder and memory, checks latency,
// memory-port behaviour, register results (observed through stores) and reset.
module tb_multicycle_datapath;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic [1:0]  ALUControl;
    logic        RegWrite, MemWrite, Branch, MemToReg, ALUScr;
    logic [63:0] Imm;
    logic        mem_req, mem_we, mem_ready;
    logic [9:0]  mem_addr, pc;
    logic [63:0] mem_wdata, mem_rdata;
    logic [2:0]  state;
    logic        retire;

    logic [63:0] dmem [0:1023];
    int n_checks = 0;
    int n_fail   = 0;

    multicycle_datapath #(.BITS(64), .ADDR_BITS(10), .BR_SHIFT(1)) dut (
        .clk(clk), .rst(rst), .Instruction(Instruction), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch), .MemToReg(MemToReg),
        .ALUScr(ALUScr), .Imm(Imm), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .state(state), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'b0};
    endfunction

    // Runs one instruction starting in a FETCH cycle; returns one cycle after retire.
    task automatic exec_instr(
        input string       tag,
        input logic [31:0] iw,
        input logic [1:0]  aluc,
        input logic        rw, mw, br, m2r, asrc,
        input logic [63:0] imm,
        input int          waits,
        input int          exp_cycles,
        input logic [9:0]  fetch_pc,
        input logic [9:0]  exp_daddr,
        input logic        chk_wdata,
        input logic [63:0] exp_wdata
    );
        int n = 0;
        int wcnt = 0;
        int got_cycles = 0;
        bit done = 0;
        bit data_phase = 0;
        ALUControl = aluc; RegWrite = rw; MemWrite = mw; Branch = br;
        MemToReg = m2r; ALUScr = asrc; Imm = imm;
        while (!done && n < 40) begin
            n++;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (mem_req) begin
                if (!data_phase) begin
                    check({tag, " fetch_addr"}, 64'(mem_addr), 64'(fetch_pc));
                    check({tag, " fetch_we"}, 64'(mem_we), 64'(0));
                    mem_ready  = 1'b1;
                    mem_rdata  = {32'h0, iw};
                    data_phase = 1;
                end else begin
                    check({tag, " data_addr"}, 64'(mem_addr), 64'(exp_daddr));
                    check({tag, " data_we"}, 64'(mem_we), 64'(mw));
                    if (chk_wdata) check({tag, " data_wdata"}, mem_wdata, exp_wdata);
                    if (wcnt < waits) begin
                        wcnt++;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = dmem[mem_addr];
                        if (mem_we) dmem[mem_addr] = mem_wdata;
                    end
                end
            end
            #1;
            if (retire) begin
                got_cycles = n;
                done = 1;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        check({tag, " retire_cycle"}, 64'(got_cycles), 64'(exp_cycles));
        check({tag, " IR"}, 64'(Instruction), 64'(iw));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        ALUControl = '0; RegWrite = 0; MemWrite = 0; Branch = 0; MemToReg = 0; ALUScr = 0; Imm = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst state", 64'(state), 64'(0));
        check("rst pc", 64'(pc), 64'(0));
        check("rst IR", 64'(Instruction), 64'(0));
        check("rst retire", 64'(retire), 64'(0));
        check("rst mem_req", 64'(mem_req), 64'(0));
        rst = 1'b0; #1;
        check("post-rst mem_req", 64'(mem_req), 64'(1));
        check("post-rst retire", 64'(retire), 64'(0));

        exec_instr("addi x1", enc(1, 0, 0), 2'b00, 1, 0, 0, 0, 1, 64'd5, 0, 4, 10'd0, 10'd0, 0, 64'd0);
        check("addi x1 pc", 64'(pc), 64'd1);
        exec_instr("addi x2", enc(2, 0, 0), 2'b00, 1, 0, 0, 0, 1, 64'd5, 0, 4, 10'd1, 10'd0, 0, 64'd0);
        exec_instr("addi x0", enc(0, 0, 0), 2'b00, 1, 0, 0, 0, 1, 64'd9, 0, 4, 10'd2, 10'd0, 0, 64'd0);
        exec_instr("beq taken", enc(0, 1, 2), 2'b01, 0, 0, 1, 0, 0, 64'd4, 0, 3, 10'd3, 10'd0, 0, 64'd0);
        check("beq taken pc", 64'(pc), 64'd11);
        check("sub 5-5 flags", 64'(dut.flags_q), 64'(4'b0101));

        exec_instr("addi dead", enc(1, 0, 0), 2'b00, 1, 0, 0, 0, 1, 64'hDEAD, 0, 4, 10'd11, 10'd0, 0, 64'd0);
        exec_instr("sw x1", enc(0, 0, 1), 2'b00, 0, 1, 0, 0, 1, 64'd7, 2, 6, 10'd12, 10'd7, 1, 64'hDEAD);
        check("sw dmem", dmem[7], 64'hDEAD);
        exec_instr("lw x3", enc(3, 0, 0), 2'b00, 1, 0, 0, 1, 1, 64'd7, 2, 7, 10'd13, 10'd7, 0, 64'd0);
        exec_instr("sw x3", enc(0, 0, 3), 2'b00, 0, 1, 0, 0, 1, 64'd9, 0, 4, 10'd14, 10'd9, 1, 64'hDEAD);
        exec_instr("sw x0", enc(0, 0, 0), 2'b00, 0, 1, 0, 0, 1, 64'd8, 0, 4, 10'd15, 10'd8, 1, 64'd0);

        exec_instr("addi max", enc(4, 0, 0), 2'b00, 1, 0, 0, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4, 10'd16, 10'd0, 0, 64'd0);
        exec_instr("add ovf", enc(5, 4, 0), 2'b00, 1, 0, 0, 0, 1, 64'd1, 0, 4, 10'd17, 10'd0, 0, 64'd0);
        check("add ovf flags", 64'(dut.flags_q), 64'(4'b1010));
        exec_instr("sw x5", enc(0, 0, 5), 2'b00, 0, 1, 0, 0, 1, 64'd10, 0, 4, 10'd18, 10'd10, 1, 64'h8000_0000_0000_0000);
        exec_instr("beq not", enc(0, 1, 0), 2'b01, 0, 0, 1, 0, 0, 64'd4, 0, 3, 10'd19, 10'd0, 0, 64'd0);
        check("beq not pc", 64'(pc), 64'd20);
        check("sub dead flags", 64'(dut.flags_q), 64'(4'b0100));

        exec_instr("andi x6", enc(6, 1, 0), 2'b10, 1, 0, 0, 0, 1, 64'hF0, 0, 4, 10'd20, 10'd0, 0, 64'd0);
        exec_instr("ori x7", enc(7, 6, 0), 2'b11, 1, 0, 0, 0, 1, 64'h3, 0, 4, 10'd21, 10'd0, 0, 64'd0);
        exec_instr("sw x7", enc(0, 0, 7), 2'b00, 0, 1, 0, 0, 1, 64'd11, 0, 4, 10'd22, 10'd11, 1, 64'hA3);

        // Stall one fetch cycle, then reset while the fetch is being accepted.
        ALUControl = '0; RegWrite = 0; MemWrite = 0; Branch = 0; MemToReg = 0; ALUScr = 0; Imm = '0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("stall state", 64'(state), 64'(0));
        check("stall pc", 64'(pc), 64'd23);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        check("rst retire", 64'(retire), 64'(0));
        check("rst mem_req", 64'(mem_req), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0; #1;
        check("mid rst state", 64'(state), 64'(0));
        check("mid rst pc", 64'(pc), 64'(0));
        check("mid rst IR", 64'(Instruction), 64'(0));
        check("mid rst retire", 64'(retire), 64'(0));

        exec_instr("sw x1 cleared", enc(0, 0, 1), 2'b00, 0, 1, 0, 0, 1, 64'd12, 0, 4, 10'd0, 10'd12, 1, 64'd0);
        exec_instr("beq to top", enc(0, 0, 0), 2'b01, 0, 0, 1, 0, 0, 64'd511, 0, 3, 10'd1, 10'd0, 0, 64'd0);
        check("beq to top pc", 64'(pc), 64'd1023);
        exec_instr("addi wrap", enc(8, 0, 0), 2'b00, 1, 0, 0, 0, 1, 64'd1, 0, 4, 10'd1023, 10'd0, 0, 64'd0);
        check("wrap pc", 64'(pc), 64'd0);
        exec_instr("nop", enc(0, 0, 0), 2'b00, 0, 0, 0, 0, 0, 64'd0, 0, 3, 10'd0, 10'd0, 0, 64'd0);
        check("nop pc", 64'(pc), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
